cache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate cache controller; master of the tag array and line data array.

---
 rtl/cache_controller_if.sv | 54 +++++
 rtl/cache_controller.sv | 143 ++++++++++++++
 tb/tb_cache_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Bundle of CPU, tag/data array and backing-memory signals seen by the cache controller.
// The master modport is the controller's view; slave is the surrounding system's view.
interface cache_controller_if #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 19,
  parameter int NUM_SETS  = 128,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32
);
  localparam int IDX_BITS = $clog2(NUM_SETS);

  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_we;
  logic [ADDR_BITS-1:0] cpu_req_addr;
  logic [WORD_BITS-1:0] cpu_req_wdata;
  logic                 cpu_resp_valid;
  logic [WORD_BITS-1:0] cpu_resp_rdata;

  logic                 tag_we;
  logic [IDX_BITS-1:0]  tag_index;
  logic [TAG_BITS-1:0]  tag_in;
  logic                 valid_in;
  logic                 dirty_in;
  logic [TAG_BITS-1:0]  tag_out;
  logic                 valid_out;
  logic                 dirty_out;
  logic                 data_we;
  logic [LINE_BITS-1:0] data_wline;
  logic [LINE_BITS-1:0] data_rline;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  tag_out, valid_out, dirty_out, data_rline, mem_ready, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output tag_we, tag_index, tag_in, valid_in, dirty_in, data_we, data_wline,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output tag_out, valid_out, dirty_out, data_rline, mem_ready, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  tag_we, tag_index, tag_in, valid_in, dirty_in, data_we, data_wline,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: lookup, victim writeback, refill.
// Tag and line arrays are external and read combinationally at tag_index.
module cache_controller #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 19,
  parameter int NUM_SETS  = 128,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32
) (
  input logic              clk,
  input logic              rst,
  cache_controller_if.master bus
);
  localparam int IDX_BITS  = $clog2(NUM_SETS);
  localparam int OFF_BITS  = ADDR_BITS - TAG_BITS - IDX_BITS;
  localparam int BYTE_OFF  = $clog2(WORD_BITS / 8);
  localparam int WSEL_BITS = OFF_BITS - BYTE_OFF;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  state_e               state_q;
  logic [IDX_BITS-1:0]  cnt_q;
  logic                 req_we_q;
  logic [TAG_BITS-1:0]  req_tag_q;
  logic [IDX_BITS-1:0]  req_idx_q;
  logic [WSEL_BITS-1:0] req_wsel_q;
  logic [WORD_BITS-1:0] req_wdata_q;

  logic                 hit;
  logic [LINE_BITS-1:0] merged_line;
  logic                 unused_byte_bits;

  assign hit              = bus.valid_out && (bus.tag_out == req_tag_q);
  assign unused_byte_bits = ^bus.cpu_req_addr[BYTE_OFF-1:0];

  always_comb begin
    merged_line = bus.data_rline;
    merged_line[req_wsel_q*WORD_BITS +: WORD_BITS] = req_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_BITS'(NUM_SETS - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.cpu_req_valid) begin
            // NOTE: request registers carry no reset; they are only consumed in states entered via this capture.
            req_we_q    <= bus.cpu_req_we;
            req_tag_q   <= bus.cpu_req_addr[ADDR_BITS-1 -: TAG_BITS];
            req_idx_q   <= bus.cpu_req_addr[OFF_BITS +: IDX_BITS];
            req_wsel_q  <= bus.cpu_req_addr[BYTE_OFF +: WSEL_BITS];
            req_wdata_q <= bus.cpu_req_wdata;
            state_q     <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit)                                state_q <= S_IDLE;
          else if (bus.valid_out && bus.dirty_out) state_q <= S_WRITEBACK;
          else                                    state_q <= S_ALLOCATE;
        end
        S_WRITEBACK: if (bus.mem_ready) state_q <= S_ALLOCATE;
        S_ALLOCATE:  if (bus.mem_ready) state_q <= S_COMPARE;
        default:     state_q <= S_INIT;
      endcase
    end
  end

  // Outputs depend on the live array read, so a hit responds in the same cycle as the lookup.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.tag_we         = 1'b0;
    bus.tag_index      = '0;
    bus.tag_in         = '0;
    bus.valid_in       = 1'b0;
    bus.dirty_in       = 1'b0;
    bus.data_we        = 1'b0;
    bus.data_wline     = '0;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    if (!rst) begin
      unique case (state_q)
        S_INIT: begin
          bus.tag_we    = 1'b1;
          bus.tag_index = cnt_q;
        end
        S_IDLE: bus.cpu_req_ready = 1'b1;
        S_COMPARE: begin
          bus.tag_index = req_idx_q;
          if (hit) begin
            bus.cpu_resp_valid = 1'b1;
            if (req_we_q) begin
              bus.data_we    = 1'b1;
              bus.data_wline = merged_line;
              bus.tag_we     = 1'b1;
              bus.tag_in     = req_tag_q;
              bus.valid_in   = 1'b1;
              bus.dirty_in   = 1'b1;
            end else begin
              bus.cpu_resp_rdata = bus.data_rline[req_wsel_q*WORD_BITS +: WORD_BITS];
            end
          end
        end
        S_WRITEBACK: begin
          bus.tag_index = req_idx_q;
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {bus.tag_out, req_idx_q, {OFF_BITS{1'b0}}};
          bus.mem_wdata = bus.data_rline;
        end
        S_ALLOCATE: begin
          bus.tag_index = req_idx_q;
          bus.mem_req   = 1'b1;
          bus.mem_addr  = {req_tag_q, req_idx_q, {OFF_BITS{1'b0}}};
          if (bus.mem_ready) begin
            bus.data_we    = 1'b1;
            bus.data_wline = bus.mem_rdata;
            bus.tag_we     = 1'b1;
            bus.tag_in     = req_tag_q;
            bus.valid_in   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: models the tag/line arrays and backing memory, and
// predicts hits, victim writebacks, refills, latency and data from a flat-memory reference.
module tb_cache_controller;
  localparam int NUM_SETS = 128;
  localparam int LB       = 512;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [LB-1:0] wdata;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if bus ();
  cache_controller dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // External tag and line arrays.
  logic [18:0]   tag_arr   [NUM_SETS];
  logic          valid_arr [NUM_SETS];
  logic          dirty_arr [NUM_SETS];
  logic [LB-1:0] line_arr  [NUM_SETS];
  logic          prefill = 1'b1;

  assign bus.tag_out    = tag_arr[bus.tag_index];
  assign bus.valid_out  = valid_arr[bus.tag_index];
  assign bus.dirty_out  = dirty_arr[bus.tag_index];
  assign bus.data_rline = line_arr[bus.tag_index];

  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        tag_arr[i]   <= 19'($urandom);
        valid_arr[i] <= 1'b1;
        dirty_arr[i] <= 1'b1;
        line_arr[i]  <= '0;
      end
    end else begin
      if (bus.tag_we) begin
        tag_arr[bus.tag_index]   <= bus.tag_in;
        valid_arr[bus.tag_index] <= bus.valid_in;
        dirty_arr[bus.tag_index] <= bus.dirty_in;
      end
      if (bus.data_we) line_arr[bus.tag_index] <= bus.data_wline;
    end
  end

  // Backing memory and flat reference memory, both keyed by line address.
  logic [LB-1:0] mem_store [logic [31:0]];
  logic [LB-1:0] ref_mem   [logic [31:0]];
  mem_txn_t      mem_log [$];
  int            mem_delay = 0;

  function automatic logic [LB-1:0] init_line(input logic [31:0] la);
    logic [LB-1:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = la ^ (32'(w) << 26) ^ 32'h1357_9BDF;
    return l;
  endfunction

  function automatic logic [LB-1:0] mem_line(input logic [31:0] la);
    if (mem_store.exists(la)) return mem_store[la];
    return init_line(la);
  endfunction

  function automatic logic [LB-1:0] ref_line(input logic [31:0] la);
    if (ref_mem.exists(la)) return ref_mem[la];
    return init_line(la);
  endfunction

  // Memory responder: completes each request after mem_delay extra cycles, checks the request holds.
  initial begin
    bit            in_txn = 0;
    int            wait_left = 0;
    mem_txn_t      snap;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (!bus.mem_req) begin
        in_txn = 0;
        bus.mem_ready = ($urandom_range(3) == 0);
      end else begin
        if (!in_txn) begin
          in_txn     = 1;
          snap.we    = bus.mem_we;
          snap.addr  = bus.mem_addr;
          snap.wdata = bus.mem_wdata;
          wait_left  = mem_delay;
        end else begin
          check("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata[LB-34:0]},
                {snap.we, snap.addr, snap.wdata[LB-34:0]});
          check("mem_hold_hi", LB'(bus.mem_wdata[LB-1:LB-33]), LB'(snap.wdata[LB-1:LB-33]));
        end
        if (wait_left == 0) begin
          bus.mem_ready = 1'b1;
          if (snap.we) mem_store[snap.addr] = snap.wdata;
          else         bus.mem_rdata = mem_line(snap.addr);
          mem_log.push_back(snap);
          in_txn = 0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Reference set occupancy: which line each set holds and whether it differs from memory.
  logic [18:0] ref_tag   [NUM_SETS];
  bit          ref_valid [NUM_SETS];
  bit          ref_dirty [NUM_SETS];

  task automatic ref_reset();
    for (int i = 0; i < NUM_SETS; i++) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
      ref_tag[i]   = '0;
    end
    ref_mem = mem_store;
  endtask

  // Entered at the negedge of the first cycle after reset release.
  task automatic init_sweep();
    for (int i = 0; i < NUM_SETS; i++) begin
      check("init_cycle",
            {bus.tag_we, bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req, bus.valid_in,
             bus.dirty_in, bus.data_we, bus.tag_index},
            {1'b1, 6'b0, 7'(i)});
      if (i == NUM_SETS - 1) bus.cpu_req_valid = 1'b0;
      @(negedge clk);
    end
    check("init_done", {bus.cpu_req_ready, bus.tag_we}, 2'b10);
  endtask

  // One CPU access, started at a negedge; returns at a negedge with the controller idle.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    logic [6:0]    idx;
    logic [18:0]   tg;
    logic [3:0]    ws;
    logic [31:0]   la, vla;
    logic [LB-1:0] line, vline;
    bit            hit, wb;
    int            n, lat, exp_lat, exp_txns;
    idx   = addr[12:6];
    tg    = addr[31:13];
    ws    = addr[5:2];
    la    = {addr[31:6], 6'b0};
    hit   = ref_valid[idx] && (ref_tag[idx] == tg);
    wb    = !hit && ref_valid[idx] && ref_dirty[idx];
    vla   = {ref_tag[idx], idx, 6'b0};
    vline = ref_line(vla);
    line  = ref_line(la);
    rdata = '0;
    mem_log.delete();

    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    n = 0;
    while (!bus.cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", bus.cpu_req_ready, 1'b1);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'($urandom);
    bus.cpu_req_addr  = $urandom;
    bus.cpu_req_wdata = $urandom;

    lat = 1;
    while (!bus.cpu_resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = hit ? 1 : (wb ? 4 + 2 * mem_delay : 3 + mem_delay);
    check("latency", lat, exp_lat);
    if (we) begin
      line[ws*32 +: 32] = wdata;
      check("store_ctl", {bus.data_we, bus.tag_we, bus.valid_in, bus.dirty_in, bus.tag_in},
            {4'b1111, tg});
      check("store_line", bus.data_wline, line);
    end else begin
      check("load_data", bus.cpu_resp_rdata, line[ws*32 +: 32]);
      rdata = bus.cpu_resp_rdata;
    end
    @(negedge clk);
    check("resp_pulse", bus.cpu_resp_valid, 1'b0);

    exp_txns = (hit ? 0 : 1) + (wb ? 1 : 0);
    check("mem_txns", mem_log.size(), exp_txns);
    if (mem_log.size() == exp_txns && exp_txns > 0) begin
      if (wb) check("wb_txn", {mem_log[0].we, mem_log[0].addr, mem_log[0].wdata},
                    {1'b1, vla, vline});
      check("refill_txn", {mem_log[exp_txns-1].we, mem_log[exp_txns-1].addr}, {1'b0, la});
    end

    ref_dirty[idx] = (hit && ref_dirty[idx]) || (we == 1'b1);
    ref_valid[idx] = 1;
    ref_tag[idx]   = tg;
    if (we) ref_mem[la] = line;
  endtask

  task automatic random_accesses(input int count);
    logic [6:0]  idx_pool [4];
    logic [18:0] tag_pool [4];
    logic [31:0] a, r;
    idx_pool = '{7'h41, 7'h00, 7'h7F, 7'h15};
    tag_pool = '{19'h0, 19'h40, 19'h1, 19'h7FFFF};
    for (int k = 0; k < count; k++) begin
      mem_delay = $urandom_range(3);
      a = {tag_pool[$urandom_range(3)], idx_pool[$urandom_range(3)], 4'($urandom), 2'($urandom)};
      do_access(1'($urandom), a, $urandom, r);
    end
  endtask

  initial begin
    logic [LB-1:0] l;
    logic [31:0]   r;
    l = init_line(32'h0000_1040);
    l[31:0] = 32'hA5A5_0001;
    mem_store[32'h0000_1040] = l;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = 32'h0000_1040;
    bus.cpu_req_wdata = '0;

    @(posedge clk);
    @(negedge clk);
    prefill = 1'b0;
    repeat (2) begin
      check("rst_outputs", {bus.tag_we, bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req,
                            bus.data_we}, 5'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ref_reset();
    init_sweep();

    do_access(1'b0, 32'h0000_1040, '0, r);
    check("cold_load", r, 32'hA5A5_0001);
    do_access(1'b0, 32'h0000_1040, '0, r);
    check("hit_load", r, 32'hA5A5_0001);
    do_access(1'b1, 32'h0000_1044, 32'hDEAD_BEEF, r);
    do_access(1'b0, 32'h0000_1044, '0, r);
    check("store_readback", r, 32'hDEAD_BEEF);
    mem_delay = 10;
    do_access(1'b0, 32'h0008_1040, '0, r);
    check("victim_state", {tag_arr[7'h41], valid_arr[7'h41], dirty_arr[7'h41]}, {19'h40, 2'b10});
    check("wb_word1", LB'(mem_store[32'h0000_1040][63:32]), LB'(32'hDEAD_BEEF));

    random_accesses(150);

    // Reset while a refill is outstanding.
    mem_delay = 20;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = 32'h0123_4580;
    for (int n = 0; n < 50 && !bus.cpu_req_ready; n++) @(negedge clk);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    for (int n = 0; n < 60 && !(bus.mem_req && !bus.mem_we); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("alloc_wait", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 32'h0123_4580});
    rst = 1'b1;
    bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    check("rst_drop", {bus.mem_req, bus.cpu_resp_valid, bus.tag_we}, 3'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ref_reset();
    init_sweep();

    random_accesses(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
